uart_port: RTL and testbench
============================

# uart_port

Responder end of the CPU's UART request/acknowledge interface: services the CPU's byte-read and byte-write handshakes and converts them to an 8N1 asynchronous serial line. Sits at the top level beside the CPU, between its UART ports and the board rx/tx pins. It contains a TX holding register plus shifter, an oversampling RX deserializer and a small RX FIFO. It also provides sticky error flags for debug.

## Interface
- CLKS_PER_BIT, default 434: clk cycles per serial bit (50 MHz / 115200); minimum 4.
- RX_FIFO_DEPTH, default 4: RX FIFO entries; must be a power of two.

- clk  input  1  system clock, all logic on rising edge
- reset  input  1  asynchronous, active-high reset
- uartReadReq  input  1  CPU requests one received byte; held until uartReadAck
- uartReadAck  output  1  one-cycle pulse; uartReadData valid in the same cycle
- uartReadData  output  8  byte popped from the RX FIFO
- uartWriteReq  input  1  CPU offers uartWriteData
- uartWriteData  input  8  byte to transmit
- uartWriteReady  output  1  holding register empty; a byte is taken when req && ready
- rx  input  1  serial input, asynchronous to clk
- tx  output  1  serial output, idle high
- rxOverrun  output  1  sticky: a received byte was dropped because the FIFO was full
- rxFrameError  output  1  sticky: stop bit sampled low

## Operation
- Reset values: tx=1, uartWriteReady=1, uartReadAck=0, uartReadData=0, rxOverrun=0, rxFrameError=0. FIFO is empty; both FSMs are idle; the holding register is empty.
- Reset mid-frame aborts the frame. tx goes high asynchronously and the partial RX byte is discarded.
- TX write handshake: the byte is accepted at an edge where uartWriteReq && uartWriteReady. It is loaded into the holding register, and uartWriteReady goes low.
- TX FSM states and transitions:
  - TX_IDLE: on the next edge with the holding register full, move the byte into the shifter, empty the holding register, go to TX_START.
  - TX_START: tx=0 for CLKS_PER_BIT cycles.
  - TX_DATA: 8 bits, LSB first, CLKS_PER_BIT cycles each.
  - TX_STOP: tx=1 for CLKS_PER_BIT cycles. Then load the holding register directly into TX_START if it is full, otherwise go to TX_IDLE.
- RX input path: rx passes through a 2-flop synchronizer before any use.
- RX FSM states and transitions:
  - RX_IDLE: a synchronized falling edge goes to RX_START.
  - RX_START: resample at CLKS_PER_BIT/2 (integer division). If high, it is a glitch: return to RX_IDLE, no flags. Otherwise go to RX_DATA.
  - RX_DATA: sample every CLKS_PER_BIT cycles, 8 bits, LSB first.
  - RX_STOP: sample once. If high, push the byte. If low, set rxFrameError and discard the byte. Both outcomes return to RX_IDLE.
- RX FIFO: head/tail pointers are log2(RX_FIFO_DEPTH)+1 bits and wrap modulo 2*RX_FIFO_DEPTH.
  - Full when the pointers differ only in the MSB.
  - A push while full drops the new byte and sets rxOverrun; FIFO contents are unchanged.
- Read handshake: on an edge where uartReadReq=1, the FIFO is non-empty and uartReadAck is currently 0:
  - uartReadAck=1 for exactly one cycle;
  - uartReadData takes the head byte;
  - head advances.
- uartReadData holds its last value until the next ack.
- Ack is never high in two consecutive cycles. A still-high req is re-evaluated the cycle after ack falls.
- Request with an empty FIFO: wait with ack low until a byte arrives. There is no timeout.
- Simultaneous push and pop on a full FIFO: both succeed, occupancy is unchanged, no overrun.
- Simultaneous push and pop on an empty FIFO: no pop that cycle; the ack comes on the following edge.
- Sticky flags clear only on reset.

## Timing
- Write accepted at edge E: uartWriteReady is low for the one cycle after E and high again after E+1.
  - tx falls after edge E+1.
  - The frame lasts exactly 10*CLKS_PER_BIT cycles.
- Back-to-back writes while the shifter is busy: the next start bit immediately follows the stop bit, with zero idle cycles.
- Write latency while the shifter is busy: uartWriteReady stays low until the holding byte moves to the shifter (end of the current stop bit).
- Read latency: ack is asserted at the first edge where req is seen with the FIFO non-empty. Minimum 1 cycle from req rising.
- RX push:
  - occurs at the stop-bit sample edge, which is 2 synchronizer cycles plus 9.5*CLKS_PER_BIT cycles after the line's start edge;
  - data is readable at the next edge.

## Test plan
- Loopback, CLKS_PER_BIT=4: write 0xA5 -> tx low 4 cycles, bits 1,0,1,0,0,1,0,1, high 4 cycles; tx tied to rx; read -> ack pulse with uartReadData=0xA5.
- Back-to-back writes 0x01, 0xFF -> uartWriteReady low 1 cycle, then low until the first stop bit ends; 80 contiguous tx cycles with no idle gap.
- Inject 5 frames 0x10..0x14 with no reads (depth 4) -> rxOverrun=1; reads return 0x10..0x13, then ack stays low.
- 1-cycle rx glitch low -> no push, no flags; frame 0x3C with stop bit low -> rxFrameError=1, FIFO still empty.
- uartReadReq held high with one byte 0x77 queued -> exactly one ack pulse and no second ack; push 0x78 -> second ack two or more cycles later.
- Assert reset mid-TX frame -> tx=1 immediately, uartWriteReady=1; a subsequent write of 0x5A transmits correctly.

Source files
------------

// File: rtl/uart_port.sv
// uart_port: CPU-facing UART responder. Converts the CPU's byte read/write
// request/acknowledge handshakes to and from an 8N1 asynchronous serial line.
//
// Parameters
//   CLKS_PER_BIT   clk cycles per serial bit (>= 4)
//   RX_FIFO_DEPTH  receive FIFO entries (power of two, >= 2)
//
// Ports
//   clk, reset                  clock, async active-high reset
//   uartReadReq/Ack/Data        CPU byte read: Ack is a 1-cycle pulse with Data
//   uartWriteReq/Data/Ready     CPU byte write: taken on req && ready
//   rx, tx                      serial line (rx asynchronous, tx idle high)
//   rxOverrun, rxFrameError     sticky debug flags, cleared only by reset
module uart_port #(
  parameter int CLKS_PER_BIT  = 434,
  parameter int RX_FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       uartReadReq,
  output logic       uartReadAck,
  output logic [7:0] uartReadData,
  input  logic       uartWriteReq,
  input  logic [7:0] uartWriteData,
  output logic       uartWriteReady,
  input  logic       rx,
  output logic       tx,
  output logic       rxOverrun,
  output logic       rxFrameError
);

  localparam int            CW        = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam int            AW        = $clog2(RX_FIFO_DEPTH);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  // ---------------------------------------------------------------- TX
  tx_state_t     tx_state, tx_state_d;
  logic [CW-1:0] tx_cnt, tx_cnt_d;
  logic [2:0]    tx_bit, tx_bit_d;
  logic [7:0]    tx_sh, tx_sh_d;
  logic          tx_d, hold_take, hold_full;
  logic [7:0]    hold_data;

  assign uartWriteReady = ~hold_full;

  // Holding register: accept and take are mutually exclusive (take needs full,
  // accept needs empty), so a single priority chain is enough.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_full <= 1'b0;
      hold_data <= '0;
    end else if (hold_take) begin
      hold_full <= 1'b0;
    end else if (uartWriteReq && !hold_full) begin
      hold_full <= 1'b1;
      hold_data <= uartWriteData;
    end
  end

  always_comb begin
    tx_state_d = tx_state;
    tx_cnt_d   = tx_cnt + 1'b1;
    tx_bit_d   = tx_bit;
    tx_sh_d    = tx_sh;
    hold_take  = 1'b0;
    case (tx_state)
      TX_IDLE: begin
        tx_cnt_d = '0;
        if (hold_full) begin
          hold_take  = 1'b1;
          tx_sh_d    = hold_data;
          tx_state_d = TX_START;
        end
      end
      TX_START: begin
        if (tx_cnt == BIT_LAST) begin
          tx_cnt_d   = '0;
          tx_bit_d   = '0;
          tx_state_d = TX_DATA;
        end
      end
      TX_DATA: begin
        if (tx_cnt == BIT_LAST) begin
          tx_cnt_d = '0;
          tx_sh_d  = {1'b0, tx_sh[7:1]};
          if (tx_bit == 3'd7) tx_state_d = TX_STOP;
          else                tx_bit_d   = tx_bit + 1'b1;
        end
      end
      TX_STOP: begin
        if (tx_cnt == BIT_LAST) begin
          tx_cnt_d = '0;
          // Chain straight into the next start bit so queued bytes go out
          // with no idle gap.
          if (hold_full) begin
            hold_take  = 1'b1;
            tx_sh_d    = hold_data;
            tx_state_d = TX_START;
          end else begin
            tx_state_d = TX_IDLE;
          end
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
    // tx is registered from the next state so the pin never glitches.
    case (tx_state_d)
      TX_START: tx_d = 1'b0;
      TX_DATA:  tx_d = tx_sh_d[0];
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_sh    <= '0;
      tx       <= 1'b1;
    end else begin
      tx_state <= tx_state_d;
      tx_cnt   <= tx_cnt_d;
      tx_bit   <= tx_bit_d;
      tx_sh    <= tx_sh_d;
      tx       <= tx_d;
    end
  end

  // ---------------------------------------------------------------- RX
  logic [1:0]    rx_sync;
  logic          rx_s, rx_prev;
  rx_state_t     rx_state, rx_state_d;
  logic [CW-1:0] rx_cnt, rx_cnt_d;
  logic [2:0]    rx_bit, rx_bit_d;
  logic [7:0]    rx_sh, rx_sh_d;
  logic          rx_push, rx_ferr;

  assign rx_s = rx_sync[1];

  always_comb begin
    rx_state_d = rx_state;
    rx_cnt_d   = rx_cnt + 1'b1;
    rx_bit_d   = rx_bit;
    rx_sh_d    = rx_sh;
    rx_push    = 1'b0;
    rx_ferr    = 1'b0;
    case (rx_state)
      RX_IDLE: begin
        rx_cnt_d = '0;
        if (rx_prev && !rx_s) rx_state_d = RX_START;
      end
      RX_START: begin
        // Mid-start-bit check rejects short low glitches.
        if (rx_cnt == HALF_LAST) begin
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
          rx_state_d = rx_s ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (rx_cnt == BIT_LAST) begin
          rx_cnt_d = '0;
          rx_sh_d  = {rx_s, rx_sh[7:1]};
          if (rx_bit == 3'd7) rx_state_d = RX_STOP;
          else                rx_bit_d   = rx_bit + 1'b1;
        end
      end
      RX_STOP: begin
        if (rx_cnt == BIT_LAST) begin
          rx_cnt_d   = '0;
          rx_push    = rx_s;
          rx_ferr    = ~rx_s;
          rx_state_d = RX_IDLE;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_sync  <= 2'b11;
      rx_prev  <= 1'b1;
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_sh    <= '0;
    end else begin
      rx_sync  <= {rx_sync[0], rx};
      rx_prev  <= rx_s;
      rx_state <= rx_state_d;
      rx_cnt   <= rx_cnt_d;
      rx_bit   <= rx_bit_d;
      rx_sh    <= rx_sh_d;
    end
  end

  // ---------------------------------------------------------------- FIFO / read
  logic [7:0]  fifo_mem [RX_FIFO_DEPTH];
  logic [AW:0] head, tail;
  logic        fifo_empty, fifo_full, pop, push_ok;

  assign fifo_empty = (head == tail);
  assign fifo_full  = (head[AW] != tail[AW]) && (head[AW-1:0] == tail[AW-1:0]);
  // Gating on the current ack guarantees a gap cycle between acks.
  assign pop        = uartReadReq && !fifo_empty && !uartReadAck;
  // When full, a same-cycle pop frees the slot being written; the read sees
  // the old contents because both are registered on the same edge.
  assign push_ok    = rx_push && (!fifo_full || pop);

  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[tail[AW-1:0]] <= rx_sh;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head         <= '0;
      tail         <= '0;
      uartReadAck  <= 1'b0;
      uartReadData <= '0;
      rxOverrun    <= 1'b0;
      rxFrameError <= 1'b0;
    end else begin
      uartReadAck <= pop;
      if (pop) begin
        uartReadData <= fifo_mem[head[AW-1:0]];
        head         <= head + 1'b1;
      end
      if (push_ok)                        tail         <= tail + 1'b1;
      if (rx_push && fifo_full && !pop)   rxOverrun    <= 1'b1;
      if (rx_ferr)                        rxFrameError <= 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_port.sv
// Directed bench for uart_port at CLKS_PER_BIT=4, depth 4. Expected read bytes
// go into a scoreboard queue when the matching serial stimulus is issued; a
// negedge monitor pops and compares on every read ack.
module tb_uart_port;
  localparam int CPB   = 4;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       uartReadReq = 1'b0;
  logic       uartReadAck;
  logic [7:0] uartReadData;
  logic       uartWriteReq = 1'b0;
  logic [7:0] uartWriteData = 8'h00;
  logic       uartWriteReady;
  logic       tb_rx = 1'b1;
  logic       lb = 1'b0;
  logic       rx_line;
  logic       tx;
  logic       rxOverrun;
  logic       rxFrameError;

  int         n_assert = 0;
  int         n_fail = 0;
  int         n_ack = 0;
  logic       prev_ack = 1'b0;
  logic [7:0] rd_q[$];

  always #5 clk = ~clk;
  assign rx_line = lb ? tx : tb_rx;

  uart_port #(.CLKS_PER_BIT(CPB), .RX_FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .uartReadReq(uartReadReq), .uartReadAck(uartReadAck), .uartReadData(uartReadData),
    .uartWriteReq(uartWriteReq), .uartWriteData(uartWriteData), .uartWriteReady(uartWriteReady),
    .rx(rx_line), .tx(tx), .rxOverrun(rxOverrun), .rxFrameError(rxFrameError)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected tx level c cycles into a frame carrying b.
  function automatic logic exp_tx(input logic [7:0] b, input int c);
    int k;
    k = c / CPB;
    if (k == 0) return 1'b0;
    if (k >= 9) return 1'b1;
    return b[k-1];
  endfunction

  // Scoreboard monitor for the read side.
  always @(negedge clk) begin
    if (!reset && uartReadAck) begin
      n_ack++;
      chk("ack_double", 32'(prev_ack), 0);
      chk("ack_expected", 32'(rd_q.size() != 0), 1);
      if (rd_q.size() != 0) chk("rd_data", 32'(uartReadData), 32'(rd_q.pop_front()));
    end
    prev_ack = uartReadAck;
  end

  task automatic send_frame(input logic [7:0] b, input logic stopv);
    @(negedge clk) tb_rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      tb_rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    tb_rx = stopv;
    repeat (CPB) @(negedge clk);
    tb_rx = 1'b1;
  endtask

  // Write one byte from idle and check the whole tx frame cycle by cycle.
  task automatic send_tx(input logic [7:0] b);
    chk("tx_ready_pre", 32'(uartWriteReady), 1);
    uartWriteReq  = 1'b1;
    uartWriteData = b;
    @(posedge clk);
    #1 uartWriteReq = 1'b0;
    @(negedge clk);
    chk("tx_ready_low", 32'(uartWriteReady), 0);
    for (int c = 0; c < 10 * CPB; c++) begin
      @(negedge clk);
      if (c == 0) chk("tx_ready_back", 32'(uartWriteReady), 1);
      chk("tx_frame_bit", 32'(tx), 32'(exp_tx(b, c)));
    end
  endtask

  task automatic do_read(input string tag);
    logic got;
    got = 1'b0;
    uartReadReq = 1'b1;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if (uartReadAck) got = 1'b1;
    end
    uartReadReq = 1'b0;
    chk(tag, 32'(got), 1);
  endtask

  task automatic try_none(input string tag, input int cycles);
    int cnt;
    cnt = 0;
    uartReadReq = 1'b1;
    repeat (cycles) begin
      @(negedge clk);
      if (uartReadAck) cnt++;
    end
    uartReadReq = 1'b0;
    chk(tag, 32'(cnt), 0);
  endtask

  task automatic pulse_reset();
    @(negedge clk) reset = 1'b1;
    @(negedge clk) reset = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int low;
    int cnt;
    int n0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_tx", 32'(tx), 1);
    chk("rst_ready", 32'(uartWriteReady), 1);
    chk("rst_ack", 32'(uartReadAck), 0);
    chk("rst_data", 32'(uartReadData), 0);
    chk("rst_ovr", 32'(rxOverrun), 0);
    chk("rst_ferr", 32'(rxFrameError), 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Loopback 0xA5
    lb = 1'b1;
    rd_q.push_back(8'hA5);
    send_tx(8'hA5);
    do_read("lb_a5_ack");
    lb = 1'b0;
    repeat (5) @(negedge clk);

    // Back-to-back writes 0x01 then 0xFF
    uartWriteReq  = 1'b1;
    uartWriteData = 8'h01;
    @(posedge clk);
    #1 uartWriteReq = 1'b0;
    @(negedge clk);
    chk("b2b_ready_low1", 32'(uartWriteReady), 0);
    low = 0;
    for (int c = 0; c < 20 * CPB; c++) begin
      @(negedge clk);
      if (c == 0) begin
        chk("b2b_ready_back", 32'(uartWriteReady), 1);
        uartWriteReq  = 1'b1;
        uartWriteData = 8'hFF;
      end
      if (c == 1) uartWriteReq = 1'b0;
      if (c >= 1 && c < 10 * CPB && !uartWriteReady) low++;
      if (c == 10 * CPB) chk("b2b_ready_after_stop", 32'(uartWriteReady), 1);
      chk("b2b_tx", 32'(tx), 32'(exp_tx((c < 10 * CPB) ? 8'h01 : 8'hFF, c % (10 * CPB))));
    end
    chk("b2b_ready_low_run", 32'(low), 10 * CPB - 1);
    @(negedge clk);
    chk("b2b_idle", 32'(tx), 1);

    // One-cycle glitch: no push, no flags
    tb_rx = 1'b0;
    @(negedge clk) tb_rx = 1'b1;
    repeat (20) @(negedge clk);
    chk("glitch_ferr", 32'(rxFrameError), 0);
    chk("glitch_ovr", 32'(rxOverrun), 0);
    try_none("glitch_no_push", 20);

    // Framing error: stop bit low, byte discarded
    send_frame(8'h3C, 1'b0);
    repeat (10) @(negedge clk);
    chk("ferr_set", 32'(rxFrameError), 1);
    chk("ferr_no_ovr", 32'(rxOverrun), 0);
    try_none("ferr_fifo_empty", 20);
    pulse_reset();
    chk("ferr_cleared", 32'(rxFrameError), 0);

    // Overrun: five frames into a depth-4 FIFO
    for (int i = 0; i < 4; i++) rd_q.push_back(8'h10 + 8'(i));
    for (int i = 0; i < 5; i++) send_frame(8'h10 + 8'(i), 1'b1);
    repeat (10) @(negedge clk);
    chk("ovr_set", 32'(rxOverrun), 1);
    chk("ovr_no_ferr", 32'(rxFrameError), 0);
    for (int i = 0; i < 4; i++) do_read("ovr_read_ack");
    try_none("ovr_empty_after", 20);
    pulse_reset();

    // Held request: one ack per byte, never back to back
    rd_q.push_back(8'h77);
    send_frame(8'h77, 1'b1);
    repeat (10) @(negedge clk);
    cnt = 0;
    uartReadReq = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (uartReadAck) cnt++;
    end
    chk("held_one_ack", 32'(cnt), 1);
    #1 n0 = n_ack;
    rd_q.push_back(8'h78);
    send_frame(8'h78, 1'b1);
    repeat (15) @(negedge clk);
    #1 chk("held_second_ack", 32'(n_ack - n0), 1);
    uartReadReq = 1'b0;
    pulse_reset();

    // Reset in the middle of a tx frame
    uartWriteReq  = 1'b1;
    uartWriteData = 8'h00;
    @(posedge clk);
    #1 uartWriteReq = 1'b0;
    repeat (10) @(negedge clk);
    chk("midtx_tx_low", 32'(tx), 0);
    #1 reset = 1'b1;
    #1;
    chk("midtx_rst_tx", 32'(tx), 1);
    chk("midtx_rst_ready", 32'(uartWriteReady), 1);
    @(negedge clk) reset = 1'b0;
    repeat (3) @(negedge clk);
    lb = 1'b1;
    rd_q.push_back(8'h5A);
    send_tx(8'h5A);
    do_read("after_rst_5a_ack");
    lb = 1'b0;

    repeat (5) @(negedge clk);
    chk("scoreboard_drained", 32'(rd_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
